lsu_core: RTL and testbench

LSU_CORE -- requirements
Module: lsu_core

---
 rtl/lsu_core.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_core.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_core.sv
// Load/store unit: one request in flight, lane-placed beats, and optional
// two-beat splitting of accesses that straddle a lane boundary.
module lsu_core #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter bit          MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [4:0]        rsp_rd,
  output logic [XLEN-1:0]   rsp_data,
  output logic              busy
);
  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned BW    = 2 * LANES;
  localparam int unsigned MW    = BW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic              unsigned_q, unsigned_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   beat0_q, beat0_d;
  logic [XLEN-1:0]   beat1_q, beat1_d;

  // Legality of the incoming request
  logic [3:0] in_nb;
  logic       in_misal;
  logic       in_illegal;

  assign in_nb      = 4'd1 << req_size;
  assign in_misal   = |(req_addr[2:0] & 3'(in_nb - 4'd1));
  assign in_illegal = ((req_size == 2'd3) && (XLEN == 32)) || (!MISALIGN_EN && in_misal);

  // Geometry of the captured request
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   sh;
  logic [3:0]        nb;
  logic              split;
  logic [ADDR_W-1:0] beat0_addr, beat1_addr;
  logic [MW-1:0]     mask_wide;
  logic [BW-1:0]     mask_full;
  logic [XLEN-1:0]   wdata_rot, rdata_shift, load_res;
  logic              sign_bit;

  assign off        = addr_q[OFFW-1:0];
  assign sh         = {off, 3'b000};
  assign nb         = 4'd1 << size_q;
  assign split      = (5'(off) + 5'(nb)) > 5'(LANES);
  assign beat0_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign beat1_addr = beat0_addr + ADDR_W'(LANES);
  assign mask_wide  = (MW'(1) << nb) - MW'(1);
  assign mask_full  = BW'(mask_wide << off);
  // Rotate left by sh: the low half of {w,w} >> (XLEN-sh) is w rotated left.
  assign wdata_rot   = XLEN'({wdata_q, wdata_q} >> (XLEN - 32'(sh)));
  assign rdata_shift = XLEN'({beat1_q, beat0_q} >> sh);

  always_comb begin
    case (size_q)
      2'd0:    sign_bit = rdata_shift[7];
      2'd1:    sign_bit = rdata_shift[15];
      2'd2:    sign_bit = rdata_shift[31];
      default: sign_bit = rdata_shift[XLEN-1];
    endcase
    load_res = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      load_res[i*8 +: 8] = (i < 32'(nb)) ? rdata_shift[i*8 +: 8]
                                         : {8{sign_bit & ~unsigned_q}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      beat0_q    <= '0;
      beat1_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      unsigned_q <= unsigned_d;
      err_q      <= err_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      beat0_q    <= beat0_d;
      beat1_q    <= beat1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    unsigned_d = unsigned_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    beat0_d    = beat0_q;
    beat1_d    = beat1_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          unsigned_d = req_unsigned;
          size_d     = req_size;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rd_d       = req_rd;
          beat0_d    = '0;
          beat1_d    = '0;
          err_d      = in_illegal;
          state_d    = in_illegal ? S_DONE : S_REQ0;
        end
      end
      S_REQ0: begin
        if (mem_gnt) begin
          if (!is_store_q)  state_d = S_WAIT0;
          else if (split)   state_d = S_REQ1;
          else              state_d = S_DONE;
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          beat0_d = mem_rdata;
          state_d = split ? S_REQ1 : S_DONE;
        end
      end
      S_REQ1: begin
        if (mem_gnt) state_d = is_store_q ? S_DONE : S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
          beat1_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = !req_ready;
  assign mem_req   = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign mem_we    = mem_req && is_store_q;
  assign mem_wdata = mem_req ? wdata_rot : '0;

  always_comb begin
    mem_addr = '0;
    mem_be   = '0;
    if (state_q == S_REQ0) begin
      mem_addr = beat0_addr;
      mem_be   = mask_full[LANES-1:0];
    end else if (state_q == S_REQ1) begin
      mem_addr = beat1_addr;
      mem_be   = mask_full[BW-1:LANES];
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rd    = rsp_valid ? rd_q : '0;
  assign rsp_data  = (rsp_valid && !err_q && !is_store_q) ? load_res : '0;

endmodule

// File: tb/tb_lsu_core.sv
// Bench for lsu_core: byte-addressed memory model answers the beats; loads and
// stores are checked against that model at byte granularity.
module tb_lsu_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        req_ready, mem_req, mem_we, rsp_valid, rsp_err, busy;
  logic [31:0] mem_addr, mem_wdata, rsp_data;
  logic [3:0]  mem_be;
  logic [4:0]  rsp_rd;

  logic        b_req_valid, b_mem_gnt, b_mem_rvalid;
  logic        b_req_ready, b_mem_req, b_mem_we, b_rsp_valid, b_rsp_err, b_busy;
  logic [31:0] b_mem_addr, b_mem_wdata, b_rsp_data;
  logic [3:0]  b_mem_be;
  logic [4:0]  b_rsp_rd;

  lsu_core dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
    .busy(busy)
  );

  lsu_core #(.MISALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_is_store(req_is_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(b_mem_req), .mem_gnt(b_mem_gnt), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rvalid(b_mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rd(b_rsp_rd), .rsp_data(b_rsp_data),
    .busy(b_busy)
  );

  int n_pass, n_total;

  logic [7:0] mem [logic [31:0]];

  bit          got_rsp, stable_ok, ready_ok, pulse_ok;
  int          lat, nbeats;
  logic        r_err;
  logic [31:0] r_data;
  logic [4:0]  r_rd;
  logic [31:0] b_addr [2];
  logic [3:0]  b_be [2];
  logic [31:0] b_wd [2];
  logic        b_we [2];

  function automatic logic [7:0] rdb(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] beat_data(input logic [31:0] a);
    return {rdb(a + 32'd3), rdb(a + 32'd2), rdb(a + 32'd1), rdb(a)};
  endfunction

  // Little-endian read of n bytes from the byte model, then extension.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int n;
    if (sz == 2'd3) return '0;
    n = 1 << sz;
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = rdb(a + 32'(k));
    if (!uns && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Issues one request on dut (caller is at a negedge) and plays memory.
  // gdel < 0: random grant delay; rdel <= 0: random rvalid delay.
  task automatic do_txn(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        input int gdel, input int rdel);
    int gcnt, rcnt;
    logic [31:0] rdat_pend, fa, fwd;
    logic [3:0] fbe;
    bit fseen;
    got_rsp = 0; stable_ok = 1; ready_ok = 1; pulse_ok = 1;
    lat = 0; nbeats = 0; r_err = 0; r_data = '0; r_rd = '0;
    gcnt = 0; rcnt = 0; fseen = 0; rdat_pend = '0; fa = '0; fwd = '0; fbe = '0;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_is_store = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
    for (int c = 1; c <= 100 && !got_rsp; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (req_ready !== 1'b0 || busy !== 1'b1) ready_ok = 0;
      if (rsp_valid === 1'b1) begin
        got_rsp = 1; lat = c; r_err = rsp_err; r_data = rsp_data; r_rd = rsp_rd;
      end else begin
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rdat_pend; end
        end
        if (mem_req === 1'b1) begin
          if (!fseen) begin
            fseen = 1; fa = mem_addr; fbe = mem_be; fwd = mem_wdata;
            gcnt = (gdel < 0) ? int'($urandom_range(3, 0)) : gdel;
          end else if (mem_addr !== fa || mem_be !== fbe || mem_wdata !== fwd) begin
            stable_ok = 0;
          end
          if (gcnt == 0) begin
            mem_gnt = 1'b1; fseen = 0;
            if (nbeats < 2) begin
              b_addr[nbeats] = mem_addr; b_be[nbeats] = mem_be;
              b_wd[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
            end
            nbeats++;
            if (mem_we === 1'b1) begin
              for (int i = 0; i < 4; i++) if (mem_be[i]) mem[mem_addr + 32'(i)] = mem_wdata[i*8 +: 8];
            end else begin
              rdat_pend = beat_data(mem_addr);
              rcnt = (rdel > 0) ? rdel : int'($urandom_range(3, 1));
            end
          end else gcnt--;
        end
        @(negedge clk);
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!got_rsp) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    end
    @(negedge clk);
    pulse_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    req_valid = 0; b_req_valid = 0; req_is_store = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    b_mem_gnt = 0; b_mem_rvalid = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_err, rsp_rd, rsp_data} !== '0
        || req_ready !== 1'b1)
      $display("FAIL reset_outputs ready=%b busy=%b mem_req=%b rsp_valid=%b, required ready=1 rest 0",
               req_ready, busy, mem_req, rsp_valid);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || b_req_ready !== 1'b1)
      $display("FAIL reset_release ready=%b busy=%b b_ready=%b, required 1 0 1", req_ready, busy, b_req_ready);
    else n_pass++;
  endtask

  task automatic test_word_store();
    do_txn(1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 5'd7, 0, 1);
    n_total++; if (!got_rsp || lat != 2) $display("FAIL store_latency got=%0d lat=%0d required 2", got_rsp, lat); else n_pass++;
    n_total++; if (nbeats != 1) $display("FAIL store_beats got %0d required 1", nbeats); else n_pass++;
    n_total++; if (b_addr[0] !== 32'h0001_0004 || b_be[0] !== 4'b1111 || b_wd[0] !== 32'hDEAD_BEEF || b_we[0] !== 1'b1)
      $display("FAIL store_beat addr=%h be=%b wd=%h we=%b required 00010004 1111 deadbeef 1", b_addr[0], b_be[0], b_wd[0], b_we[0]);
    else n_pass++;
    n_total++; if (r_err !== 1'b0 || r_data !== '0 || r_rd !== 5'd7)
      $display("FAIL store_rsp err=%b data=%h rd=%0d required 0 0 7", r_err, r_data, r_rd);
    else n_pass++;
    n_total++; if (!pulse_ok) $display("FAIL store_pulse rsp_valid=%b ready=%b required 0 1", rsp_valid, req_ready); else n_pass++;
  endtask

  task automatic test_byte_load();
    mem[32'h0001_0000] = 8'hFF; mem[32'h0001_0001] = 8'hFF;
    mem[32'h0001_0002] = 8'hFF; mem[32'h0001_0003] = 8'h80;
    do_txn(1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0, 5'd3, 0, 1);
    n_total++; if (!got_rsp || lat != 3) $display("FAIL load_min_latency got=%0d lat=%0d required 3", got_rsp, lat); else n_pass++;
    n_total++; if (b_addr[0] !== 32'h0001_0000 || b_be[0] !== 4'b1000 || b_we[0] !== 1'b0)
      $display("FAIL byte_beat addr=%h be=%b we=%b required 00010000 1000 0", b_addr[0], b_be[0], b_we[0]);
    else n_pass++;
    n_total++; if (r_data !== 32'hFFFF_FF80 || r_rd !== 5'd3) $display("FAIL byte_signed data=%h rd=%0d required ffffff80 3", r_data, r_rd); else n_pass++;
    do_txn(1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0, 5'd4, -1, 0);
    n_total++; if (r_data !== 32'h0000_0080) $display("FAIL byte_unsigned data=%h required 00000080", r_data); else n_pass++;
  endtask

  task automatic test_split_load();
    mem[32'h0001_0004] = 8'h00; mem[32'h0001_0005] = 8'h00;
    mem[32'h0001_0006] = 8'hBB; mem[32'h0001_0007] = 8'hAA;
    mem[32'h0001_0008] = 8'hDD; mem[32'h0001_0009] = 8'hCC;
    mem[32'h0001_000A] = 8'h00; mem[32'h0001_000B] = 8'h00;
    do_txn(1'b0, 2'd2, 1'b0, 32'h0001_0006, 32'h0, 5'd12, -1, 0);
    n_total++; if (nbeats != 2) $display("FAIL split_beats got %0d required 2", nbeats); else n_pass++;
    n_total++; if (b_addr[0] !== 32'h0001_0004 || b_be[0] !== 4'b1100 || b_addr[1] !== 32'h0001_0008 || b_be[1] !== 4'b0011)
      $display("FAIL split_addr_be %h/%b %h/%b required 00010004/1100 00010008/0011", b_addr[0], b_be[0], b_addr[1], b_be[1]);
    else n_pass++;
    n_total++; if (r_data !== 32'hCCDD_AABB || r_err !== 1'b0) $display("FAIL split_data data=%h err=%b required ccddaabb 0", r_data, r_err); else n_pass++;
  endtask

  task automatic test_illegal();
    bit seen_req, seen_rsp;
    logic e;
    logic [31:0] d;
    logic [4:0] r;
    do_txn(1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0, 5'd21, -1, 0);
    n_total++; if (!got_rsp || lat != 1 || nbeats != 0)
      $display("FAIL dword_reject got=%0d lat=%0d beats=%0d required 1 1 0", got_rsp, lat, nbeats);
    else n_pass++;
    n_total++; if (r_err !== 1'b1 || r_data !== '0 || r_rd !== 5'd21)
      $display("FAIL dword_reject_rsp err=%b data=%h rd=%0d required 1 0 21", r_err, r_data, r_rd);
    else n_pass++;
    for (int t = 0; t < 2; t++) begin
      seen_req = 0; seen_rsp = 0; e = 0; d = '1; r = '0;
      b_req_valid = 1'b1; req_is_store = 1'b0; req_unsigned = 1'b0;
      req_size = (t == 0) ? 2'd2 : 2'd3;
      req_addr = (t == 0) ? 32'h0001_0006 : 32'h0001_0000;
      req_rd = 5'(9 + t);
      @(negedge clk);
      b_req_valid = 1'b0;
      for (int c = 0; c < 10 && !seen_rsp; c++) begin
        if (b_mem_req === 1'b1) seen_req = 1;
        if (b_rsp_valid === 1'b1) begin
          seen_rsp = 1; e = b_rsp_err; d = b_rsp_data; r = b_rsp_rd;
        end else @(negedge clk);
      end
      n_total++; if (!seen_rsp || seen_req)
        $display("FAIL nomis_reject_%0d rsp_seen=%0d mem_req_seen=%0d required 1 0", t, seen_rsp, seen_req);
      else n_pass++;
      n_total++; if (e !== 1'b1 || d !== '0 || r !== 5'(9 + t))
        $display("FAIL nomis_rsp_%0d err=%b data=%h rd=%0d required 1 0 %0d", t, e, d, r, 9 + t);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_gnt_stall();
    do_txn(1'b1, 2'd2, 1'b0, 32'h0001_0020, 32'h1234_5678, 5'd1, 5, 1);
    n_total++; if (!stable_ok || !ready_ok) $display("FAIL stall_stable stable=%0d ready_low=%0d required 1 1", stable_ok, ready_ok); else n_pass++;
    n_total++; if (lat != 7) $display("FAIL stall_latency lat=%0d required 7", lat); else n_pass++;
    do_txn(1'b0, 2'd1, 1'b0, 32'h0001_0023, 32'h0, 5'd2, 5, 2);
    n_total++; if (!stable_ok || !ready_ok || nbeats != 2)
      $display("FAIL stall_split stable=%0d ready_low=%0d beats=%0d required 1 1 2", stable_ok, ready_ok, nbeats);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    exp = exp_load(32'hFFFF_FFFE, 2'd2, 1'b0);
    do_txn(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, 5'd30, -1, 0);
    n_total++; if (nbeats != 2 || b_addr[0] !== 32'hFFFF_FFFC || b_addr[1] !== 32'h0)
      $display("FAIL wrap_addr beats=%0d a0=%h a1=%h required 2 fffffffc 00000000", nbeats, b_addr[0], b_addr[1]);
    else n_pass++;
    n_total++; if (r_data !== exp) $display("FAIL wrap_data got %h required %h", r_data, exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 2'd2, 1'b0, 32'h0001_0080, 32'hA5C3_0F69, 5'd5, 0, 1);
    do_txn(1'b0, 2'd2, 1'b0, 32'h0001_0080, 32'h0, 5'd6, 0, 1);
    n_total++; if (!got_rsp || lat != 3 || r_data !== 32'hA5C3_0F69)
      $display("FAIL b2b_load lat=%0d data=%h required 3 a5c30f69", lat, r_data);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      logic st, uns, we_ok, bytes_ok;
      logic [1:0] sz;
      logic [31:0] a, wd, exp;
      logic [4:0] rd;
      int n, ben;
      bit spl;
      st = 1'($urandom); uns = 1'($urandom);
      sz = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      a = ($urandom_range(7, 0) == 0) ? $urandom : 32'h2000_0000 + 32'($urandom_range(63, 0));
      wd = $urandom; rd = 5'($urandom);
      n = 1 << sz;
      spl = ((a % 4) + 32'(n)) > 4;
      if (st && sz != 2'd3) for (int k = 0; k < n; k++) mem[a + 32'(k)] = ~wd[8*k +: 8];
      exp = exp_load(a, sz, uns);
      do_txn(st, sz, uns, a, wd, rd, -1, 0);
      n_total++; if (!got_rsp || r_rd !== rd) $display("FAIL rnd%0d_rsp got=%0d rd=%0d required 1 %0d", it, got_rsp, r_rd, rd); else n_pass++;
      n_total++; if (!stable_ok || !ready_ok || !pulse_ok)
        $display("FAIL rnd%0d_handshake stable=%0d ready=%0d pulse=%0d required 1 1 1", it, stable_ok, ready_ok, pulse_ok);
      else n_pass++;
      if (sz == 2'd3) begin
        n_total++; if (r_err !== 1'b1 || nbeats != 0 || r_data !== '0)
          $display("FAIL rnd%0d_illegal err=%b beats=%0d data=%h required 1 0 0", it, r_err, nbeats, r_data);
        else n_pass++;
      end else begin
        n_total++; if (r_err !== 1'b0 || nbeats != (spl ? 2 : 1))
          $display("FAIL rnd%0d_beats err=%b beats=%0d required 0 %0d", it, r_err, nbeats, spl ? 2 : 1);
        else n_pass++;
        n_total++; if (b_addr[0] !== {a[31:2], 2'b00} || (spl && b_addr[1] !== {a[31:2], 2'b00} + 32'd4))
          $display("FAIL rnd%0d_addr a0=%h a1=%h for addr %h", it, b_addr[0], b_addr[1], a);
        else n_pass++;
        we_ok = 1; ben = 0;
        for (int b = 0; b < nbeats && b < 2; b++) begin
          if (b_we[b] !== st) we_ok = 0;
          ben += $countones(b_be[b]);
        end
        n_total++; if (!we_ok) $display("FAIL rnd%0d_we got %b required %b", it, b_we[0], st); else n_pass++;
        if (st) begin
          bytes_ok = 1;
          for (int k = 0; k < n; k++) if (rdb(a + 32'(k)) !== wd[8*k +: 8]) bytes_ok = 0;
          n_total++; if (!bytes_ok || ben != n || r_data !== '0)
            $display("FAIL rnd%0d_store bytes_ok=%0d enabled=%0d data=%h required 1 %0d 0", it, bytes_ok, ben, r_data, n);
          else n_pass++;
        end else begin
          n_total++; if (r_data !== exp) $display("FAIL rnd%0d_load got %h required %h", it, r_data, exp); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0001_0040; req_rd = 5'd17;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (mem_req !== 1'b1) $display("FAIL rstmid_req0 mem_req=%b required 1", mem_req); else n_pass++;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_total++; if (busy !== 1'b1 || mem_req !== 1'b0) $display("FAIL rstmid_wait0 busy=%b mem_req=%b required 1 0", busy, mem_req); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_err, rsp_rd, rsp_data} !== '0 || req_ready !== 1'b1)
      $display("FAIL rstmid_outputs busy=%b mem_req=%b rsp_valid=%b ready=%b required 0 0 0 1", busy, mem_req, rsp_valid, req_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1;
    end
    n_total++; if (seen) $display("FAIL rstmid_late_rvalid rsp_valid=%b ready=%b required 0 1", rsp_valid, req_ready); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_split_load();
    test_illegal();
    test_gnt_stall();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
